// File: rtl/addr_gen_pkg.sv
// Shared types and constants for the strided address generator.
package addr_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_STRIDE = 4;

endpackage

// File: rtl/strided_addr_gen_if.sv
// Address stream from the generator to its consumer: valid/ready handshake plus last marker.
interface strided_addr_gen_if #(
  parameter int unsigned WIDTH = 16
);

  logic             addr_valid;
  logic             addr_ready;
  logic [WIDTH-1:0] addr_out;
  logic             last;

  modport master (
    output addr_valid,
    output addr_out,
    output last,
    input  addr_ready
  );

  modport slave (
    input  addr_valid,
    input  addr_out,
    input  last,
    output addr_ready
  );

endinterface

// File: rtl/en_reg.sv
// Generic enabled register with asynchronous active-low reset to zero.
module en_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled, clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/loop_counter.sv
// Loop index with synchronous clear, increment and terminal-count flag against a limit.
module loop_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             at_end_c
);

  logic [CNT_W-1:0] idx_q;

  // Index register; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (inc) begin
      idx_q <= idx_q + CNT_W'(1);
    end
  end

  // Index sits on the final iteration of this loop.
  assign at_end_c = (idx_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/strided_addr_gen.sv
// Two-level strided address generator: inner_count addresses per row, outer_count rows.
module strided_addr_gen
  import addr_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         base_addr,
  input  logic [WIDTH-1:0]         inner_stride,
  input  logic [CNT_W-1:0]         inner_count,
  input  logic [WIDTH-1:0]         outer_stride,
  input  logic [CNT_W-1:0]         outer_count,
  output logic                     busy,
  output logic                     done,
  strided_addr_gen_if.master       addr_if
);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             run, hs, cnt_ok, cap, last_c;
  logic             inner_end, outer_end;
  logic             inner_clr, inner_inc, outer_clr, outer_inc;
  logic             addr_en, row_en;
  logic [WIDTH-1:0] addr_q, addr_d, row_base_q, row_base_d;
  logic [WIDTH-1:0] inner_stride_q, outer_stride_q;
  logic [CNT_W-1:0] inner_count_q, outer_count_q;

  assign run    = (state_q == RUN);
  assign hs     = run & addr_if.addr_ready;
  assign cnt_ok = (|inner_count) & (|outer_count);
  assign cap    = ~clear & (state_q == IDLE) & start & cnt_ok;
  assign last_c = run & inner_end & outer_end;

  // State and done pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next state and done; clear aborts silently from either state.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cnt_ok) state_d = RUN;
            else        done_d  = 1'b1;
          end
        end
        RUN: begin
          if (hs && last_c) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Loop-index control and address datapath selection.
  always_comb begin
    inner_clr  = cap | clear | (hs & inner_end);
    inner_inc  = hs & ~inner_end;
    outer_clr  = cap | clear | (hs & inner_end & outer_end);
    outer_inc  = hs & inner_end & ~outer_end;
    row_en     = cap | (~clear & outer_inc);
    row_base_d = cap ? base_addr : (row_base_q + outer_stride_q);
    addr_en    = cap | (~clear & hs & ~last_c);
    if (cap)            addr_d = base_addr;
    else if (inner_end) addr_d = row_base_q + outer_stride_q;
    else                addr_d = addr_q + inner_stride_q;
  end

  // Configuration captured only on an accepted start.
  en_reg #(.W(WIDTH)) u_inner_stride (.clk(clk), .rst_n(rst), .en(cap), .d(inner_stride), .q(inner_stride_q));
  en_reg #(.W(WIDTH)) u_outer_stride (.clk(clk), .rst_n(rst), .en(cap), .d(outer_stride), .q(outer_stride_q));
  en_reg #(.W(CNT_W)) u_inner_count  (.clk(clk), .rst_n(rst), .en(cap), .d(inner_count),  .q(inner_count_q));
  en_reg #(.W(CNT_W)) u_outer_count  (.clk(clk), .rst_n(rst), .en(cap), .d(outer_count),  .q(outer_count_q));

  // Current address and start-of-row address.
  en_reg #(.W(WIDTH)) u_addr     (.clk(clk), .rst_n(rst), .en(addr_en), .d(addr_d),     .q(addr_q));
  en_reg #(.W(WIDTH)) u_row_base (.clk(clk), .rst_n(rst), .en(row_en),  .d(row_base_d), .q(row_base_q));

  // Inner (within row) and outer (row) loop indices.
  loop_counter #(.CNT_W(CNT_W)) u_inner (
    .clk(clk), .rst_n(rst), .clr(inner_clr), .inc(inner_inc),
    .limit(inner_count_q), .at_end_c(inner_end)
  );

  loop_counter #(.CNT_W(CNT_W)) u_outer (
    .clk(clk), .rst_n(rst), .clr(outer_clr), .inc(outer_inc),
    .limit(outer_count_q), .at_end_c(outer_end)
  );

  assign busy               = run;
  assign done               = done_q;
  assign addr_if.addr_valid = run;
  assign addr_if.addr_out   = addr_q;
  assign addr_if.last       = last_c;

endmodule

// File: tb/tb_strided_addr_gen.sv
// Self-checking bench: queue-based reference model plus directed literal scenarios and random traffic.
module tb_strided_addr_gen;
  import addr_gen_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] base_addr = '0;
  logic [WIDTH-1:0] inner_stride = '0;
  logic [WIDTH-1:0] outer_stride = '0;
  logic [CNT_W-1:0] inner_count = '0;
  logic [CNT_W-1:0] outer_count = '0;
  logic             busy, done;

  int checks = 0;
  int errors = 0;

  logic [15:0] e36 [6] = '{16'h0100, 16'h0104, 16'h0108, 16'h0140, 16'h0144, 16'h0148};
  logic [15:0] e38 [4] = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};

  strided_addr_gen_if #(.WIDTH(WIDTH)) bus ();

  strided_addr_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .base_addr(base_addr), .inner_stride(inner_stride), .inner_count(inner_count),
    .outer_stride(outer_stride), .outer_count(outer_count),
    .busy(busy), .done(done), .addr_if(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start expands into the full address list; each handshake pops one.
  logic [15:0] m_q[$];
  bit          m_done = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (clear) begin
        m_q.delete();
      end else if (m_q.size() == 0) begin
        if (start) begin
          if (inner_count == 0 || outer_count == 0) begin
            m_done = 1'b1;
          end else begin
            for (int o = 0; o < int'(outer_count); o++)
              for (int i = 0; i < int'(inner_count); i++)
                m_q.push_back(16'(int'(base_addr) + o * int'(outer_stride) + i * int'(inner_stride)));
          end
        end
      end else if (bus.addr_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("cmp_valid", 32'(bus.addr_valid), 32'(m_q.size() != 0));
    chk("cmp_busy",  32'(busy),           32'(m_q.size() != 0));
    chk("cmp_done",  32'(done),           32'(m_done));
    if (m_q.size() != 0) begin
      chk("cmp_addr", 32'(bus.addr_out), 32'(m_q[0]));
      chk("cmp_last", 32'(bus.last),     32'(m_q.size() == 1));
    end
  end

  task automatic scramble();
    base_addr    = 16'($urandom);
    inner_stride = 16'($urandom);
    outer_stride = 16'($urandom);
    inner_count  = 8'($urandom_range(0, 4));
    outer_count  = 8'($urandom_range(0, 4));
  endtask

  // Present a start for one cycle; returns on the falling edge where the first address is visible.
  task automatic launch(input logic [15:0] b, input logic [15:0] is, input logic [7:0] ic,
                        input logic [15:0] os, input logic [7:0] oc);
    @(negedge clk);
    base_addr = b; inner_stride = is; inner_count = ic; outer_stride = os; outer_count = oc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  task automatic run_fixed(input string tag);
    bus.addr_ready = 1'b1;
    launch(16'h0100, 16'(DEFAULT_STRIDE), 8'd3, 16'h0040, 8'd2);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, "_addr"}, 32'(bus.addr_out), 32'(e36[k]));
      chk({tag, "_last"}, 32'(bus.last), 32'(k == 5));
    end
    @(negedge clk);
    chk({tag, "_done"},  32'(done), 32'd1);
    chk({tag, "_valid"}, 32'(bus.addr_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] obs[$];
    bit got_done;

    bus.addr_ready = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.addr_valid), 32'd0);
    chk("rst_addr",  32'(bus.addr_out),   32'd0);
    chk("rst_last",  32'(bus.last),       32'd0);
    chk("rst_busy",  32'(busy),           32'd0);
    chk("rst_done",  32'(done),           32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Two rows of three at full throughput.
    run_fixed("r36");

    // Stalling consumer: ready pattern 1,0,0,1 repeated.
    launch(16'h0100, 16'd4, 8'd3, 16'h0040, 8'd2);
    got_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.addr_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (bus.addr_valid && bus.addr_ready) obs.push_back(bus.addr_out);
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("r37_done_seen", 32'(got_done), 32'd1);
    chk("r37_count", 32'(obs.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      if (k < obs.size()) chk("r37_addr", 32'(obs[k]), 32'(e36[k]));

    // Wrap-around modulo 2^16.
    bus.addr_ready = 1'b1;
    launch(16'hFFF8, 16'd4, 8'd4, 16'h0000, 8'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("r38_addr", 32'(bus.addr_out), 32'(e38[k]));
    end
    @(negedge clk);
    chk("r38_done", 32'(done), 32'd1);

    // Zero-length start.
    @(negedge clk);
    launch(16'h1234, 16'd4, 8'd0, 16'h0010, 8'd3);
    chk("r39_done",  32'(done), 32'd1);
    chk("r39_valid", 32'(bus.addr_valid), 32'd0);
    @(negedge clk);
    chk("r39_done_once", 32'(done), 32'd0);
    chk("r39_valid2",    32'(bus.addr_valid), 32'd0);

    // Clear after the third handshake.
    launch(16'h0100, 16'd4, 8'd3, 16'h0040, 8'd2);
    repeat (3) @(negedge clk);
    chk("r40_addr_pre", 32'(bus.addr_out), 32'h0140);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("r40_valid", 32'(bus.addr_valid), 32'd0);
    chk("r40_busy",  32'(busy), 32'd0);
    chk("r40_done",  32'(done), 32'd0);
    @(negedge clk);
    chk("r40_done2", 32'(done), 32'd0);
    run_fixed("r40_restart");

    // Asynchronous reset mid-sequence, off the clock edge.
    launch(16'h0100, 16'd4, 8'd3, 16'h0040, 8'd2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("r41_valid", 32'(bus.addr_valid), 32'd0);
    chk("r41_addr",  32'(bus.addr_out),   32'd0);
    chk("r41_last",  32'(bus.last),       32'd0);
    chk("r41_busy",  32'(busy),           32'd0);
    chk("r41_done",  32'(done),           32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_fixed("r41_after");

    // Random traffic: starts, clears, stalls and configuration churn.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      start          = ($urandom_range(0, 3) == 0);
      clear          = ($urandom_range(0, 39) == 0);
      bus.addr_ready = ($urandom_range(0, 3) != 0);
      scramble();
      if ($urandom_range(0, 3) == 0) inner_stride = 16'(DEFAULT_STRIDE);
    end
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    bus.addr_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
